// File: rtl/occupancy_sensor_decoder_pkg.sv
// Shared definitions for the door-sensor direction decoder: state encoding,
// parameter defaults and sensor polarity.
package occupancy_sensor_decoder_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 64;

  // Raw sensor level that means "beam interrupted".
  localparam logic BEAM_BROKEN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_IN1        = 3'd1,
    ST_IN2        = 3'd2,
    ST_IN3        = 3'd3,
    ST_OUT1       = 3'd4,
    ST_OUT2       = 3'd5,
    ST_OUT3       = 3'd6,
    ST_WAIT_CLEAR = 3'd7
  } state_e;

  // True for the states in which a passage is in progress and the timer runs.
  function automatic logic in_passage(input state_e s);
    return (s != ST_IDLE) && (s != ST_WAIT_CLEAR);
  endfunction

endpackage

// File: rtl/occupancy_sensor_decoder_sensor_debouncer.sv
// Two-flop synchroniser followed by a consecutive-sample debounce filter;
// the output is 1 while the beam is considered broken.
module sensor_debouncer
  import occupancy_sensor_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic level
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          broken_s;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  assign broken_s = (sync2_r == BEAM_BROKEN);
  assign level    = level_r;

  // Metastability synchroniser for the asynchronous raw beam input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sensor;
      sync2_r <= sync1_r;
    end
  end

  // Level follows the synced sample only after DEBOUNCE_CYCLES disagreeing samples in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (broken_s == level_r) begin
      level_r <= level_r;
      cnt_r   <= '0;
    end else if (cnt_r == CNT_LAST) begin
      level_r <= broken_s;
      cnt_r   <= '0;
    end else begin
      level_r <= level_r;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/occupancy_sensor_decoder.sv
// Door direction decoder: debounces the outer (A) and inner (B) beams and
// turns completed entry/exit sequences into single-cycle count pulses.
module occupancy_sensor_decoder
  import occupancy_sensor_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic inc_enable,
  output logic dec_enable,
  output logic seq_error,
  output logic busy,
  output logic a_db,
  output logic b_db
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic          a_db_s;
  logic          b_db_s;
  state_e        state_r;
  state_e        state_s;
  logic          inc_s;
  logic          dec_s;
  logic          err_s;
  logic          inc_r;
  logic          dec_r;
  logic          err_r;
  logic          busy_r;
  logic          timeout_s;
  logic [TW-1:0] timer_r;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor_a),
    .level  (a_db_s)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor_b),
    .level  (b_db_s)
  );

  assign a_db       = a_db_s;
  assign b_db       = b_db_s;
  assign inc_enable = inc_r;
  assign dec_enable = dec_r;
  assign seq_error  = err_r;
  assign busy       = busy_r;

  // The next increment would reach the limit, so the passage is abandoned on this edge.
  assign timeout_s = in_passage(state_r) && (timer_r >= TMO_LAST);

  // Next-state and pulse decode; timeout takes priority over the normal transition.
  always_comb begin
    state_s = state_r;
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    err_s   = 1'b0;
    if (timeout_s) begin
      state_s = ST_WAIT_CLEAR;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          case ({a_db_s, b_db_s})
            2'b10:   state_s = ST_IN1;
            2'b01:   state_s = ST_OUT1;
            2'b11:   begin state_s = ST_WAIT_CLEAR; err_s = 1'b1; end
            default: state_s = ST_IDLE;
          endcase
        end
        ST_IN1: begin
          case ({a_db_s, b_db_s})
            2'b11:   state_s = ST_IN2;
            2'b01:   state_s = ST_IN3;
            2'b00:   state_s = ST_IDLE;
            default: state_s = ST_IN1;
          endcase
        end
        ST_IN2: begin
          case ({a_db_s, b_db_s})
            2'b01:   state_s = ST_IN3;
            2'b10:   state_s = ST_IN1;
            2'b00:   begin state_s = ST_IDLE; err_s = 1'b1; end
            default: state_s = ST_IN2;
          endcase
        end
        ST_IN3: begin
          case ({a_db_s, b_db_s})
            2'b00:   begin state_s = ST_IDLE; inc_s = 1'b1; end
            2'b11:   state_s = ST_IN2;
            2'b10:   state_s = ST_IN1;
            default: state_s = ST_IN3;
          endcase
        end
        // Exit path mirrors the entry path with the beams swapped.
        ST_OUT1: begin
          case ({a_db_s, b_db_s})
            2'b11:   state_s = ST_OUT2;
            2'b10:   state_s = ST_OUT3;
            2'b00:   state_s = ST_IDLE;
            default: state_s = ST_OUT1;
          endcase
        end
        ST_OUT2: begin
          case ({a_db_s, b_db_s})
            2'b10:   state_s = ST_OUT3;
            2'b01:   state_s = ST_OUT1;
            2'b00:   begin state_s = ST_IDLE; err_s = 1'b1; end
            default: state_s = ST_OUT2;
          endcase
        end
        ST_OUT3: begin
          case ({a_db_s, b_db_s})
            2'b00:   begin state_s = ST_IDLE; dec_s = 1'b1; end
            2'b11:   state_s = ST_OUT2;
            2'b01:   state_s = ST_OUT1;
            default: state_s = ST_OUT3;
          endcase
        end
        ST_WAIT_CLEAR: begin
          case ({a_db_s, b_db_s})
            2'b00:   state_s = ST_IDLE;
            default: state_s = ST_WAIT_CLEAR;
          endcase
        end
        default: begin
          state_s = ST_WAIT_CLEAR;
          err_s   = 1'b1;
        end
      endcase
    end
  end

  // State register and registered pulse/busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      inc_r   <= 1'b0;
      dec_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      inc_r   <= inc_s;
      dec_r   <= dec_s;
      err_r   <= err_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Passage timer: cleared in IDLE, counts during a passage, frozen in WAIT_CLEAR, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= '0;
    end else if (state_r == ST_IDLE) begin
      timer_r <= '0;
    end else if (in_passage(state_r) && (timer_r != TMO_MAX)) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

endmodule

// File: tb/tb_occupancy_sensor_decoder.sv
// Table-driven bench for the door direction decoder with a pulse scoreboard.
module tb_occupancy_sensor_decoder;

  localparam int D       = 4;
  localparam int T       = 64;
  localparam int LAT     = D + 3;
  localparam int TMO_LAT = D + 3 + T;
  localparam int K_NONE  = 0;
  localparam int K_INC   = 1;
  localparam int K_DEC   = 2;
  localparam int K_ERR   = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic inc_enable, dec_enable, seq_error, busy, a_db, b_db;

  typedef struct { int kind; int cyc; } exp_t;
  typedef struct {
    logic a; logic b; int cycles; int kind; int lat;
    logic busy; logic adb; logic bdb;
  } step_t;

  exp_t  sb_q[$];
  step_t steps[$];
  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;
  int    a_hi_cnt = 0;
  logic  prev_pulse = 1'b0;

  occupancy_sensor_decoder #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_a   (sensor_a),
    .sensor_b   (sensor_b),
    .inc_enable (inc_enable),
    .dec_enable (dec_enable),
    .seq_error  (seq_error),
    .busy       (busy),
    .a_db       (a_db),
    .b_db       (b_db)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    int   kind;
    exp_t e;
    if (a_db) a_hi_cnt <= a_hi_cnt + 1;
    if (inc_enable || dec_enable || seq_error) begin
      kind = inc_enable ? K_INC : (dec_enable ? K_DEC : K_ERR);
      check("pulse_exclusive", $countones({inc_enable, dec_enable, seq_error}), 1);
      check("pulse_width", int'(prev_pulse), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", kind, K_NONE);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
    prev_pulse <= inc_enable | dec_enable | seq_error;
  end

  task automatic add(input logic a, input logic b, input int n, input int kind, input int lat,
                     input logic bz, input logic adb, input logic bdb);
    steps.push_back('{a, b, n, kind, lat, bz, adb, bdb});
  endtask

  task automatic run_step(input step_t s);
    int start;
    sensor_a = s.a;
    sensor_b = s.b;
    start = cyc;
    if (s.kind != K_NONE) sb_q.push_back('{s.kind, start + s.lat});
    repeat (s.cycles) @(negedge clk);
    check("busy", int'(busy), int'(s.busy));
    check("a_db", int'(a_db), int'(s.adb));
    check("b_db", int'(b_db), int'(s.bdb));
  endtask

  function automatic int all_outs();
    return int'({inc_enable, dec_enable, seq_error, busy, a_db, b_db});
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    // entry, exit, five back-to-back exits, turn-back, simultaneous break, timeout
    add(1'b1, 1'b0, 10, K_NONE, 0,   1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 10, K_NONE, 0,   1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 10, K_NONE, 0,   1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 20, K_INC,  LAT, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 10, K_NONE, 0,   1'b1, 1'b0, 1'b1);
    add(1'b1, 1'b1, 10, K_NONE, 0,   1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 10, K_NONE, 0,   1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 20, K_DEC,  LAT, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add(1'b0, 1'b1, 8, K_NONE, 0,   1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b1, 8, K_NONE, 0,   1'b1, 1'b1, 1'b1);
      add(1'b1, 1'b0, 8, K_NONE, 0,   1'b1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 8, K_DEC,  LAT, 1'b0, 1'b0, 1'b0);
    end
    add(1'b1, 1'b0, 10,  K_NONE, 0,       1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 20,  K_NONE, 0,       1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 10,  K_ERR,  LAT,     1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b0, 20,  K_NONE, 0,       1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 100, K_ERR,  TMO_LAT, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 20,  K_NONE, 0,       1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    foreach (steps[i]) run_step(steps[i]);
    check("table_queue_drained", sb_q.size(), 0);

    // 3-cycle glitch on A must never reach the debounced level
    snap = a_hi_cnt;
    sensor_a = 1'b1;
    repeat (3) @(negedge clk);
    sensor_a = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_a_db", a_hi_cnt - snap, 0);
    check("glitch_busy", int'(busy), 0);

    // reset in IN3, B released while reset is held: no pulse afterwards
    sensor_a = 1'b1;
    repeat (10) @(negedge clk);
    sensor_b = 1'b1;
    repeat (10) @(negedge clk);
    sensor_a = 1'b0;
    repeat (10) @(negedge clk);
    check("in3_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("midreset_outputs", all_outs(), 0);
    sensor_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_busy", int'(busy), 0);

    // beam still broken across reset is seen as a fresh arrival
    sensor_a = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("held_reset_a_db", int'(a_db), 0);
    repeat (12) @(negedge clk);
    check("fresh_event_busy", int'(busy), 1);
    sensor_a = 1'b0;
    repeat (20) @(negedge clk);
    check("fresh_event_idle", int'(busy), 0);
    check("final_queue_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
